// File: rtl/sram_dual_sync_be_clr.sv
// sram_dual_sync_be_clr: true dual-port synchronous RAM with byte enables,
// selectable read-during-write result, optional output register and a
// clear engine that sweeps every word to CLEAR_VALUE.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   ADDR0/ADDR1        port addresses
//   DATA0/DATA1        port write data
//   cen0/cen1          port enables (gate read and write)
//   we0/we1            write enables, qualified by cen
//   be0/be1            byte-lane write enables
//   Q0/Q1              registered read data (latency 1, or 2 with OUT_REG)
//   clr_req            one-cycle clear request
//   busy               high while a clear sweep runs
//   clr_done           one-cycle pulse when a sweep completes
module sram_dual_sync_be_clr #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_WIDTH = 8,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            ADDR0,
    input  logic [ADDR_WIDTH-1:0]            ADDR1,
    input  logic [DATA_WIDTH-1:0]            DATA0,
    input  logic [DATA_WIDTH-1:0]            DATA1,
    input  logic                             cen0,
    input  logic                             cen1,
    input  logic                             we0,
    input  logic                             we1,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be0,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be1,
    output logic [DATA_WIDTH-1:0]            Q0,
    output logic [DATA_WIDTH-1:0]            Q1,
    input  logic                             clr_req,
    output logic                             busy,
    output logic                             clr_done
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  rst_q;
    logic                  clearing, wr0, wr1;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [DATA_WIDTH-1:0] old0, old1, new0, new1, rd0, rd1;
    logic [DATA_WIDTH-1:0] dq0_q, dq1_q, oq0_q, oq1_q;
    logic                  en0_q, en1_q;

    assign clearing = state_q == CLEAR;
    assign clr_addr = cnt_q[ADDR_WIDTH-1:0];
    // user writes are dropped while the sweep owns the array
    assign wr0 = cen0 & we0 & ~clearing;
    assign wr1 = cen1 & we1 & ~clearing;
    assign old0 = mem[ADDR0];
    assign old1 = mem[ADDR1];

    // Post-write word seen at each port's address. Port 1 lanes are applied
    // first so port 0 wins any lane both ports enable on a shared address.
    always_comb begin
        new0 = old0;
        new1 = old1;
        for (int i = 0; i < NB; i++) begin
            if (wr1 && be1[i]) begin
                new1[i*BYTE_WIDTH +: BYTE_WIDTH] = DATA1[i*BYTE_WIDTH +: BYTE_WIDTH];
                if (ADDR0 == ADDR1) new0[i*BYTE_WIDTH +: BYTE_WIDTH] = DATA1[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (wr0 && be0[i]) begin
                new0[i*BYTE_WIDTH +: BYTE_WIDTH] = DATA0[i*BYTE_WIDTH +: BYTE_WIDTH];
                if (ADDR0 == ADDR1) new1[i*BYTE_WIDTH +: BYTE_WIDTH] = DATA0[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // the sweep write counts as the write for read-during-write purposes
    assign rd0 = RDW_MODE == 0 ? old0 : (clearing && ADDR0 == clr_addr) ? CLEAR_VALUE : new0;
    assign rd1 = RDW_MODE == 0 ? old1 : (clearing && ADDR1 == clr_addr) ? CLEAR_VALUE : new1;

    // both ports write the fully merged word, so a shared address gets the
    // same value from each
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clearing) mem[clr_addr] <= CLEAR_VALUE;
            else begin
                if (wr0) mem[ADDR0] <= new0;
                if (wr1) mem[ADDR1] <= new1;
            end
        end
    end

    // rst_q marks the first cycle after reset for the automatic sweep;
    // the extra counter bit flags the last address without wrap ambiguity
    always_comb begin
        state_d = state_q;
        cnt_d = '0;
        unique case (state_q)
            IDLE: if (clr_req || (CLEAR_ON_RESET && rst_q)) state_d = CLEAR;
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d[ADDR_WIDTH]) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            rst_q <= 1'b1;
            dq0_q <= '0;
            dq1_q <= '0;
            oq0_q <= '0;
            oq1_q <= '0;
            en0_q <= 1'b0;
            en1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            rst_q <= 1'b0;
            if (cen0) dq0_q <= rd0;
            if (cen1) dq1_q <= rd1;
            en0_q <= cen0;
            en1_q <= cen1;
            // the output stage only advances behind a real read, so it holds too
            if (en0_q) oq0_q <= dq0_q;
            if (en1_q) oq1_q <= dq1_q;
        end
    end

    assign Q0 = OUT_REG != 0 ? oq0_q : dq0_q;
    assign Q1 = OUT_REG != 0 ? oq1_q : dq1_q;
    assign busy = state_q == CLEAR;
    assign clr_done = state_q == DONE;
endmodule

// File: tb/tb_sram_dual_sync_be_clr.sv
// tb_sram_dual_sync_be_clr: directed checks of the default RAM and an
// RDW_MODE=1 / OUT_REG=1 copy driven with identical stimulus
module tb_sram_dual_sync_be_clr;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  ADDR0 = '0, ADDR1 = '0;
    logic [15:0] DATA0 = '0, DATA1 = '0;
    logic        cen0 = 1'b0, cen1 = 1'b0, we0 = 1'b0, we1 = 1'b0, clr_req = 1'b0;
    logic [1:0]  be0 = '0, be1 = '0;
    logic [15:0] q0a, q1a, q0b, q1b;
    logic        busya, busyb, donea, doneb;
    int          vec = 0, miss = 0;
    int          nbusy, ndone;

    always #5 clk = ~clk;

    sram_dual_sync_be_clr u_a (
        .clk(clk), .rst(rst), .ADDR0(ADDR0), .ADDR1(ADDR1), .DATA0(DATA0), .DATA1(DATA1),
        .cen0(cen0), .cen1(cen1), .we0(we0), .we1(we1), .be0(be0), .be1(be1),
        .Q0(q0a), .Q1(q1a), .clr_req(clr_req), .busy(busya), .clr_done(donea)
    );

    sram_dual_sync_be_clr #(.RDW_MODE(1), .OUT_REG(1)) u_b (
        .clk(clk), .rst(rst), .ADDR0(ADDR0), .ADDR1(ADDR1), .DATA0(DATA0), .DATA1(DATA1),
        .cen0(cen0), .cen1(cen1), .we0(we0), .we1(we1), .be0(be0), .be1(be1),
        .Q0(q0b), .Q1(q1b), .clr_req(clr_req), .busy(busyb), .clr_done(doneb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cen0 = 1'b0; cen1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    endtask

    task automatic wr0(input logic [9:0] a, input logic [15:0] d, input logic [1:0] b);
        cen0 = 1'b1; we0 = 1'b1; ADDR0 = a; DATA0 = d; be0 = b;
    endtask

    task automatic wr1(input logic [9:0] a, input logic [15:0] d, input logic [1:0] b);
        cen1 = 1'b1; we1 = 1'b1; ADDR1 = a; DATA1 = d; be1 = b;
    endtask

    task automatic rd0(input logic [9:0] a);
        cen0 = 1'b1; we0 = 1'b0; ADDR0 = a;
    endtask

    task automatic rd1(input logic [9:0] a);
        cen1 = 1'b1; we1 = 1'b0; ADDR1 = a;
    endtask

    initial begin
        tick(); tick();
        chk("rst_q0", q0a, 0); chk("rst_q1", q1a, 0); chk("rst_q0_oreg", q0b, 0);
        chk("rst_busy", busya, 0); chk("rst_done", donea, 0);
        rst = 1'b0;
        nbusy = 0; ndone = 0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            nbusy += busya;
            ndone += donea;
        end
        chk("sweep_busy_cycles", nbusy, 1024);
        chk("sweep_done_pulses", ndone, 1);

        rd0(0); tick(); idle(); chk("clr_rd0", q0a, 16'h0000);
        rd0(511); tick(); idle(); chk("clr_rd511", q0a, 16'h0000);
        rd0(1023); wr1(1023, 16'hFFFF, 2'b11); tick(); idle(); chk("clr_rd1023", q0a, 16'h0000);
        tick(); chk("clr_rd1023_oreg_new", q0b, 16'hFFFF);

        wr0(5, 16'h1234, 2'b11); tick(); idle();
        wr0(5, 16'hABCD, 2'b10); tick(); idle();
        rd1(5); tick(); idle(); chk("be_merge", q1a, 16'hAB34);
        tick(); chk("be_merge_oreg", q1b, 16'hAB34);
        wr0(5, 16'hFFFF, 2'b00); tick(); idle(); chk("be_zero_read", q0a, 16'hAB34);
        rd1(5); tick(); idle(); chk("be_zero_nowrite", q1a, 16'hAB34);

        wr0(9, 16'h1111, 2'b01); wr1(9, 16'h2222, 2'b11); tick(); idle();
        rd0(9); tick(); idle(); chk("collision", q0a, 16'h2211);
        tick(); chk("collision_oreg", q0b, 16'h2211);

        wr0(3, 16'h0F0F, 2'b11); tick(); idle();
        wr0(3, 16'h5A5A, 2'b11); rd1(3); tick(); idle();
        chk("rdw_old_other", q1a, 16'h0F0F); chk("rdw_old_same", q0a, 16'h0F0F);
        tick();
        chk("rdw_new_other", q1b, 16'h5A5A); chk("rdw_new_same", q0b, 16'h5A5A);

        wr1(7, 16'hBEEF, 2'b11); tick(); idle();
        rd0(7); tick(); idle();
        chk("lat1", q0a, 16'hBEEF); chk("lat2_first_edge", q0b, 16'h5A5A);
        tick(); chk("lat2_second_edge", q0b, 16'hBEEF);
        ADDR0 = 0; tick(); tick();
        chk("hold_oreg", q0b, 16'hBEEF); chk("hold", q0a, 16'hBEEF);

        wr0(1000, 16'h7777, 2'b11); tick(); idle();
        wr0(600, 16'h4444, 2'b11); tick(); idle();
        wr0(500, 16'h5555, 2'b11); tick(); idle();
        wr0(499, 16'h3333, 2'b11); tick(); idle();
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        chk("req_busy", busya, 1);
        for (int i = 1; i <= 500; i++) begin
            if (i == 11) wr0(1000, 16'hFFFF, 2'b11);
            if (i == 200) clr_req = 1'b1;
            tick(); idle(); clr_req = 1'b0;
        end
        chk("busy_before_abort", busya, 1);
        rst = 1'b1; clr_req = 1'b1; tick(); clr_req = 1'b0;
        chk("abort_busy", busya, 0); chk("abort_q0", q0a, 0);
        chk("abort_q0_oreg", q0b, 0); chk("abort_done", donea, 0);
        rst = 1'b0; tick();
        chk("restart_busy", busya, 1);
        rd0(1000); rd1(600); tick(); idle();
        chk("drop_write_1000", q0a, 16'h7777); chk("keep_600", q1a, 16'h4444);
        rd0(499); rd1(500); tick(); idle();
        chk("cleared_499", q0a, 16'h0000); chk("keep_500", q1a, 16'h5555);
        ndone = 0;
        for (int i = 0; i < 1100 && ndone == 0; i++) begin
            tick();
            ndone += donea;
        end
        chk("restart_done", ndone, 1);
        chk("idle_after_done", busya, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
